fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 145 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO read port.
// Every frame is start, DSIZE data bits LSB first, optional even parity, then stop bit(s).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | line high; pop and load the head word when tx_en && !rempty
//   START  | start bit (low) for one bit time
//   DATA   | shreg[0] on the line; shift right at the end of each bit
//   PARITY | stored even parity for one bit time (PARITY_EN=1 only)
//   STOP   | line high for STOP_BITS bit times
module fifo_uart_tx #(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             tx_en,
  output logic             tx,
  output logic             busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DSIZE + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DSIZE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    baud_cnt, baud_nxt;
  logic [CW-1:0]    bit_cnt, bit_nxt;
  logic [DSIZE-1:0] shreg, shreg_nxt;
  logic             par_q, par_nxt;
  logic             tx_nxt, busy_nxt, rinc_nxt;
  logic             baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      rinc     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      par_q    <= par_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      rinc     <= rinc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_q;
    rinc_nxt  = 1'b0;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b0;

    case (state)
      IDLE: begin
        // The pop and the capture share this edge, so rdata is still the head word.
        if (tx_en && !rempty) begin
          state_nxt = START;
          shreg_nxt = rdata;
          par_nxt   = ^rdata;
          baud_nxt  = '0;
          bit_nxt   = '0;
          rinc_nxt  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          shreg_nxt = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx and busy are registered from the next state so they line up with it.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: instance 0 is 8N1 and instance 1 is 8E2, both at 4 clocks per bit.
// Each instance drains its own FIFO model, and every decoded frame is checked against a scoreboard.
module tb_fifo_uart_tx;
  localparam int C = 4;

  logic            rclk = 1'b0;
  logic            rrst;
  logic [1:0]      ten_v;
  logic [1:0]      tx_v, busy_v, rinc_v, rempty_v;
  logic [1:0][7:0] rdata_v;

  logic [7:0] mem [2][16];
  int         wp[2] = '{0, 0};
  int         rp[2] = '{0, 0};
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  int         rinc_t[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         lost = 0;

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         len;
    logic       exp_par;
  } vec_t;
  vec_t vecs[3];

  always #5 rclk = ~rclk;

  assign rempty_v = {(wp[1] == rp[1]), (wp[0] == rp[0])};
  assign rdata_v  = {mem[1][rp[1][3:0]], mem[0][rp[0][3:0]]};

  always @(posedge rclk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < 2; s++)
      if (rinc_v[s] && rp[s] != wp[s]) rp[s] <= rp[s] + 1;
  end

  always @(negedge rclk) if (rinc_v[0]) rinc_t.push_back(cyc);

  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .rclk(rclk), .rrst(rrst), .rempty(rempty_v[0]), .rdata(rdata_v[0]),
    .rinc(rinc_v[0]), .tx_en(ten_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .rclk(rclk), .rrst(rrst), .rempty(rempty_v[1]), .rdata(rdata_v[1]),
    .rinc(rinc_v[1]), .tx_en(ten_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] v);
    mem[sel][wp[sel][3:0]] = v;
    wp[sel]++;
    if (sel == 1) sb1.push_back(v);
    else sb0.push_back(v);
  endtask

  // Walks one frame cycle by cycle at negedges; may drop tx_en or assert rrst at a given cycle.
  task automatic check_frame(input int sel, input int len, input int drop_at, input int rst_at,
                             output logic par_o);
    int         n = 0;
    int         idx;
    logic [7:0] d, got;
    logic       expb;
    bit         pen;
    pen   = (sel == 1);
    par_o = 1'bx;
    got   = '0;
    while (busy_v[sel] !== 1'b1 && n < 300) begin
      @(negedge rclk);
      n++;
    end
    if (busy_v[sel] !== 1'b1) begin
      chk("frame_start_timeout", 32'(busy_v[sel]), 32'd1);
      return;
    end
    if ((sel == 1 ? sb1.size() : sb0.size()) == 0) begin
      chk("scoreboard_underflow", 32'd0, 32'd1);
      return;
    end
    d = (sel == 1) ? sb1.pop_front() : sb0.pop_front();
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge rclk);
      if (i == rst_at) begin
        rrst = 1'b1;
        #1;
        chk("reset_tx", 32'(tx_v[sel]), 32'd1);
        chk("reset_busy", 32'(busy_v[sel]), 32'd0);
        chk("reset_rinc", 32'(rinc_v[sel]), 32'd0);
        lost++;
        return;
      end
      if (i == drop_at) ten_v[sel] = 1'b0;
      idx = i / C;
      if (idx == 0) expb = 1'b0;
      else if (idx <= 8) expb = d[idx-1];
      else if (pen && idx == 9) expb = ^d;
      else expb = 1'b1;
      chk("tx_bit", 32'(tx_v[sel]), 32'(expb));
      chk("busy_in_frame", 32'(busy_v[sel]), 32'd1);
      chk("rinc_pulse", 32'(rinc_v[sel]), (i == 0) ? 32'd1 : 32'd0);
      if (i % C == C / 2) begin
        if (idx >= 1 && idx <= 8) got[idx-1] = tx_v[sel];
        if (pen && idx == 9) par_o = tx_v[sel];
      end
    end
    @(negedge rclk);
    chk("frame_end_busy", 32'(busy_v[sel]), 32'd0);
    chk("frame_end_tx", 32'(tx_v[sel]), 32'd1);
    chk("decoded_byte", 32'(got), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic par;
    int   bad;
    vecs[0] = '{sel: 0, data: 8'hA5, len: 40, exp_par: 1'b0};
    vecs[1] = '{sel: 1, data: 8'h07, len: 48, exp_par: 1'b1};
    vecs[2] = '{sel: 1, data: 8'h03, len: 48, exp_par: 1'b0};

    rrst  = 1'b1;
    ten_v = 2'b00;
    repeat (2) @(negedge rclk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_tx", 32'(tx_v[s]), 32'd1);
      chk("rst_busy", 32'(busy_v[s]), 32'd0);
      chk("rst_rinc", 32'(rinc_v[s]), 32'd0);
    end
    rrst  = 1'b0;
    ten_v = 2'b11;

    bad = 0;
    repeat (100) begin
      @(negedge rclk);
      if (rinc_v !== 2'b00 || tx_v !== 2'b11 || busy_v !== 2'b00) bad++;
    end
    chk("empty_idle_cycles_bad", 32'(bad), 32'd0);

    foreach (vecs[k]) begin
      push(vecs[k].sel, vecs[k].data);
      check_frame(vecs[k].sel, vecs[k].len, -1, -1, par);
      if (vecs[k].sel == 1) chk("parity_bit", 32'(par), 32'(vecs[k].exp_par));
    end

    rinc_t.delete();
    push(0, 8'h01);
    push(0, 8'h80);
    push(0, 8'hFF);
    repeat (3) check_frame(0, 40, -1, -1, par);
    chk("b2b_pop_count", 32'(rinc_t.size()), 32'd3);
    if (rinc_t.size() == 3) begin
      chk("b2b_gap1", 32'(rinc_t[1] - rinc_t[0]), 32'd41);
      chk("b2b_gap2", 32'(rinc_t[2] - rinc_t[1]), 32'd41);
    end
    bad = 0;
    repeat (50) begin
      @(negedge rclk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rempty_v[0] !== 1'b1) bad++;
    end
    chk("b2b_after_idle_bad", 32'(bad), 32'd0);

    ten_v[0] = 1'b0;
    push(0, 8'h3C);
    bad = 0;
    repeat (20) begin
      @(negedge rclk);
      if (rinc_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
    end
    chk("disabled_no_pop_bad", 32'(bad), 32'd0);
    chk("disabled_fifo_level", 32'(wp[0] - rp[0]), 32'd1);
    ten_v[0] = 1'b1;
    @(negedge rclk);
    chk("pop_after_enable", 32'(rinc_v[0]), 32'd1);
    check_frame(0, 40, -1, -1, par);

    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    check_frame(0, 40, 10, -1, par);
    bad = 0;
    repeat (60) begin
      @(negedge rclk);
      if (rinc_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad++;
    end
    chk("txen_drop_no_pop_bad", 32'(bad), 32'd0);
    chk("txen_drop_fifo_level", 32'(wp[0] - rp[0]), 32'd2);
    ten_v[0] = 1'b1;
    repeat (2) check_frame(0, 40, -1, -1, par);

    push(0, 8'hA5);
    push(0, 8'h5A);
    check_frame(0, 40, -1, 15, par);
    @(negedge rclk);
    chk("rst_hold_tx", 32'(tx_v[0]), 32'd1);
    chk("rst_one_word_popped", 32'(wp[0] - rp[0]), 32'd1);
    rrst = 1'b0;
    check_frame(0, 40, -1, -1, par);
    chk("words_lost", 32'(lost), 32'd1);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
